// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and constants for the 4-slot TDM demultiplexer
package tdm_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [1:0] SLOT_D0 = 2'b00;
   localparam logic [1:0] SLOT_D1 = 2'b01;
   localparam logic [1:0] SLOT_D2 = 2'b10;
   localparam logic [1:0] SLOT_D3 = 2'b11;

   localparam int NUM_SLOTS = 4;

endpackage

// File: rtl/tdm_demux4_if.sv
// rtl/tdm_demux4_if.sv - slot stream in, held parallel channels out
interface tdm_demux4_if #(
   parameter int WIDTH = 1
);
   logic             din_valid;
   logic [WIDTH-1:0] din;
   logic             din_sof;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic [WIDTH-1:0] d3;
   logic             frame_valid;

   modport master (
      output din_valid, din, din_sof,
      input  d0, d1, d2, d3, frame_valid
   );

   modport slave (
      input  din_valid, din, din_sof,
      output d0, d1, d2, d3, frame_valid
   );
endinterface

// File: rtl/tdm_slot_ctrl.sv
// rtl/tdm_slot_ctrl.sv - frame lock FSM, slot counter and violation detection
module tdm_slot_ctrl
   import tdm_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din_valid,
   input  logic                 din_sof,
   output logic [NUM_SLOTS-1:0] stage_en,
   output logic                 publish,
   output logic                 err,
   output logic                 locked,
   output logic [1:0]           slot,
   output logic                 frame_err
);

   state_t state;

   assign locked = (state == RUN);

   // Strobes act on the same edge that samples the beat, so they stay combinational.
   always_comb begin
      stage_en = '0;
      publish  = 1'b0;
      err      = 1'b0;
      if (din_valid) begin
         if (state == HUNT) begin
            stage_en[SLOT_D0] = din_sof;
         end else if (din_sof) begin
            stage_en[SLOT_D0] = 1'b1;
            err               = (slot != SLOT_D0);
         end else if (slot == SLOT_D0) begin
            err = 1'b1;
         end else if (slot == SLOT_D3) begin
            publish = 1'b1;
         end else begin
            stage_en[slot] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= HUNT;
         slot      <= SLOT_D0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= err;
         if (din_valid) begin
            if (din_sof) begin
               state <= RUN;
               slot  <= SLOT_D1;
            end else if (state == RUN) begin
               if (slot == SLOT_D0) begin
                  state <= HUNT;
                  slot  <= SLOT_D0;
               end else begin
                  slot <= slot + 2'd1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - TDM 1-to-4 demultiplexer publishing only complete frames
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   tdm_demux4_if.slave      bus,
   output logic             locked,
   output logic [1:0]       slot,
   output logic             frame_err,
   output logic [ERR_W-1:0] err_cnt
);

   logic [NUM_SLOTS-1:0] stage_en;
   logic                 publish;
   logic                 err;
   logic [WIDTH-1:0]     stage0, stage1, stage2;

   tdm_slot_ctrl u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .din_valid (bus.din_valid),
      .din_sof   (bus.din_sof),
      .stage_en  (stage_en),
      .publish   (publish),
      .err       (err),
      .locked    (locked),
      .slot      (slot),
      .frame_err (frame_err)
   );

   // Slot 3 is taken straight from din so the whole frame lands on one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage0          <= '0;
         stage1          <= '0;
         stage2          <= '0;
         bus.d0          <= '0;
         bus.d1          <= '0;
         bus.d2          <= '0;
         bus.d3          <= '0;
         bus.frame_valid <= 1'b0;
         err_cnt         <= '0;
      end else begin
         bus.frame_valid <= publish;
         if (stage_en[SLOT_D0]) stage0 <= bus.din;
         if (stage_en[SLOT_D1]) stage1 <= bus.din;
         if (stage_en[SLOT_D2]) stage2 <= bus.din;
         if (publish) begin
            bus.d0 <= stage0;
            bus.d1 <= stage1;
            bus.d2 <= stage2;
            bus.d3 <= bus.din;
         end
         if (err && (err_cnt != {ERR_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - scoreboard bench for tdm_demux4
module tb_tdm_demux4;

   localparam int ERR_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             locked;
   logic [1:0]       slot;
   logic             frame_err;
   logic [ERR_W-1:0] err_cnt;

   int checks   = 0;
   int failures = 0;

   logic [3:0]       frame_q[$];
   logic [ERR_W-1:0] err_q[$];

   tdm_demux4_if #(.WIDTH(1)) bus ();

   tdm_demux4 #(.WIDTH(1), .ERR_W(ERR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .locked    (locked),
      .slot      (slot),
      .frame_err (frame_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic beat(input logic sof, input logic d);
      @(negedge clk);
      bus.din_valid = 1'b1;
      bus.din_sof   = sof;
      bus.din       = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.din_valid = 1'b0;
         bus.din_sof   = 1'b0;
         bus.din       = 1'b0;
      end
   endtask

   // Monitor: every output pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && bus.frame_valid) begin
         if (frame_q.size() == 0) check("unexpected_frame_valid", 1, 0);
         else check("frame_data", {bus.d0, bus.d1, bus.d2, bus.d3}, frame_q.pop_front());
      end
      if (!rst && frame_err) begin
         if (err_q.size() == 0) check("unexpected_frame_err", 1, 0);
         else check("err_cnt", err_cnt, err_q.pop_front());
      end
   end

   initial begin
      bus.din_valid = 1'b0;
      bus.din_sof   = 1'b0;
      bus.din       = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_d", {bus.d0, bus.d1, bus.d2, bus.d3}, 4'b0000);
      check("reset_flags", {bus.frame_valid, locked, slot, frame_err}, 5'b0);
      check("reset_err_cnt", err_cnt, 0);
      rst = 1'b0;

      // 1: basic frame 1,0,1,1
      frame_q.push_back(4'b1011);
      beat(1, 1); beat(0, 0); beat(0, 1); beat(0, 1);
      idle(1);
      check("t1_locked", locked, 1);
      check("t1_slot", slot, 0);
      idle(2);

      // 2: same frame with 3 idle cycles between beats
      frame_q.push_back(4'b1011);
      beat(1, 1); idle(1);
      check("t2_slot_gap_a", slot, 1);
      idle(2);
      check("t2_slot_gap_b", slot, 1);
      beat(0, 0); idle(3);
      check("t2_slot_gap_c", slot, 2);
      beat(0, 1); idle(3);
      check("t2_slot_gap_d", slot, 3);
      beat(0, 1); idle(3);
      check("t2_slot_end", slot, 0);

      // 3: early sof after slot 1
      beat(1, 1); beat(0, 0);
      err_q.push_back(2'd1);
      beat(1, 0);
      idle(1);
      check("t3_held_d", {bus.d0, bus.d1, bus.d2, bus.d3}, 4'b1011);
      check("t3_locked", locked, 1);
      check("t3_slot", slot, 1);
      frame_q.push_back(4'b0110);
      beat(0, 1); beat(0, 1); beat(0, 0);
      idle(2);

      // 4: missing sof while locked
      err_q.push_back(2'd2);
      beat(0, 1);
      idle(1);
      check("t4_unlocked", locked, 0);
      beat(0, 0); beat(0, 1);
      idle(1);
      check("t4_still_hunt", {locked, slot}, 3'b000);
      beat(1, 1);
      idle(1);
      check("t4_relock", {locked, slot}, 3'b101);
      frame_q.push_back(4'b1001);
      beat(0, 0); beat(0, 0); beat(0, 1);
      idle(2);

      // 5: asynchronous reset after slot 2
      beat(1, 1); beat(0, 1); beat(0, 1);
      @(negedge clk);
      bus.din_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("t5_rst_d", {bus.d0, bus.d1, bus.d2, bus.d3}, 4'b0000);
      check("t5_rst_flags", {locked, slot, err_cnt}, 5'b0);
      @(negedge clk);
      rst = 1'b0;
      frame_q.push_back(4'b0110);
      beat(1, 0); beat(0, 1); beat(0, 1); beat(0, 0);
      idle(2);

      // 6: saturation with repeated early sof
      beat(1, 0);
      for (int i = 0; i < 5; i++) begin
         err_q.push_back((i < 3) ? ERR_W'(i + 1) : 2'd3);
         beat(1, 1);
      end
      idle(2);
      check("t6_err_cnt_final", err_cnt, 3);

      idle(3);
      check("frame_q_drained", frame_q.size(), 0);
      check("err_q_drained", err_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
